// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mult_pkg;

    localparam int MULT_WIDTH  = 32;
    localparam int MULT_DIGITS = 17;
    localparam int ACC_WIDTH   = 36;
    localparam int EXT_WIDTH   = MULT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_POS1,
        DIG_POS2,
        DIG_NEG1,
        DIG_NEG2
    } booth_digit_t;

    // Bits are {MR[1], MR[0], x_minus}.
    function automatic booth_digit_t booth_decode(input logic [2:0] bits);
        booth_digit_t d;
        case (bits)
            3'b001, 3'b010: d = DIG_POS1;
            3'b011:         d = DIG_POS2;
            3'b100:         d = DIG_NEG2;
            3'b101, 3'b110: d = DIG_NEG1;
            default:        d = DIG_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Radix-4 Booth partial-product selector: picks 0, +-M or +-2M, sign-extended to the
// accumulator width. Negation is returned as invert plus a carry-in for the adder.
module booth_digit_sel
    import mult_pkg::*;
(
    input  logic                 x_plus,
    input  logic                 x,
    input  logic                 x_minus,
    input  logic [EXT_WIDTH-1:0] m,
    output logic [ACC_WIDTH-1:0] pp,
    output logic                 neg
);

    logic [ACC_WIDTH-1:0] m_ext;
    logic [ACC_WIDTH-1:0] m_dbl;

    assign m_ext = {{2{m[EXT_WIDTH-1]}}, m};
    assign m_dbl = {m[EXT_WIDTH-1], m, 1'b0};

    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (booth_decode({x_plus, x, x_minus}))
            DIG_POS1: pp = m_ext;
            DIG_POS2: pp = m_dbl;
            DIG_NEG1: begin
                pp  = ~m_ext;
                neg = 1'b1;
            end
            DIG_NEG2: begin
                pp  = ~m_dbl;
                neg = 1'b1;
            end
            default:  pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, 64-bit signed/unsigned product.
// Optional early termination (FINISH state + alignment shifter) with BOOTH_MULT_EARLY_TERM_EN.
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int DIGITS = (WIDTH + 2) / 2;

    state_t               state;
    state_t               state_next;
    logic [ACC_WIDTH-1:0] hi;
    logic [EXT_WIDTH-1:0] lo;
    logic [EXT_WIDTH-1:0] mr;
    logic                 x_minus;
    logic [EXT_WIDTH-1:0] m;
    logic [4:0]           count;

    logic [ACC_WIDTH-1:0] pp;
    logic                 neg;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] hi_next;
    logic [EXT_WIDTH-1:0] lo_next;
    logic                 last_step;
    logic                 do_step;
    logic                 et_hit;

    booth_digit_sel u_sel (
        .x_plus  (mr[1]),
        .x       (mr[0]),
        .x_minus (x_minus),
        .m       (m),
        .pp      (pp),
        .neg     (neg)
    );

    assign sum       = hi + pp + {{(ACC_WIDTH-1){1'b0}}, neg};
    assign hi_next   = {{2{sum[ACC_WIDTH-1]}}, sum[ACC_WIDTH-1:2]};
    assign lo_next   = {sum[1:0], lo[EXT_WIDTH-1:2]};
    assign last_step = (count == 5'(DIGITS - 1));

`ifdef BOOTH_MULT_EARLY_TERM_EN
    // All remaining digits are zero once MR and x_minus are pure sign copies.
    assign et_hit = (mr == {EXT_WIDTH{mr[EXT_WIDTH-1]}}) && (x_minus == mr[EXT_WIDTH-1]);

    logic [6:0] fin_shamt;
    assign fin_shamt = 7'(2 * DIGITS) - {1'b0, count, 1'b0};
`else
    assign et_hit = 1'b0;
`endif

    assign do_step = (state == BUSY) && !et_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (et_hit)         state_next = FINISH;
                else if (last_step) state_next = DONE;
            end
`ifdef BOOTH_MULT_EARLY_TERM_EN
            FINISH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one Booth step per BUSY cycle, result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            mr      <= '0;
            x_minus <= 1'b0;
            m       <= '0;
            count   <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            m       <= {{2{is_signed & y[WIDTH-1]}}, y};
            mr      <= {{2{is_signed & x[WIDTH-1]}}, x};
            x_minus <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
        end else if (do_step) begin
            hi      <= hi_next;
            lo      <= lo_next;
            mr      <= {{2{mr[EXT_WIDTH-1]}}, mr[EXT_WIDTH-1:2]};
            x_minus <= mr[1];
            count   <= count + 5'd1;
            if (last_step) product <= {hi_next[2*WIDTH-EXT_WIDTH-1:0], lo_next};
        end
`ifdef BOOTH_MULT_EARLY_TERM_EN
        else if (state == FINISH) begin
            product <= 64'($signed({hi, lo}) >>> fin_shamt);
        end
`endif
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table, corner sequences and random pairs
// scored against a behavioural multiply through an expected-result queue.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_signed;
    logic [31:0] y;
    logic [31:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    always #5 clk = ~clk;

    booth_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .is_signed (is_signed),
        .y         (y),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

`ifdef BOOTH_MULT_EARLY_TERM_EN
    localparam int FIXED_LAT = -1;
    localparam int ET_LAT    = 4;
    localparam int ZERO_LAT  = 2;
`else
    localparam int FIXED_LAT = 17;
    localparam int ET_LAT    = 17;
    localparam int ZERO_LAT  = 17;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_accept = 0;
    logic [63:0] sb_q[$];
    vec_t        vecs[10];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [63:0] exp);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        is_signed = sgn;
        y         = a;
        x         = b;
        in_valid  = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid    = 1'b0;
        last_accept = cyc;
    endtask

    task automatic waitResult(input string name, input int exp_lat, input bit retire);
        int          cycles = 0;
        logic [63:0] exp;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            checkOutput({name, "_timeout"}, 64'(out_valid), 64'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            return;
        end
        if (exp_lat >= 0) checkOutput({name, "_latency"}, 64'(cycles), 64'(exp_lat));
        if (sb_q.size() == 0) begin
            checkOutput({name, "_unexpected"}, 64'(sb_q.size()), 64'd1);
            return;
        end
        exp = sb_q.pop_front();
        checkOutput(name, product, exp);
        if (retire) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          prev_accept;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        bit          seen_valid;

        vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{1'b0, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A};
        vecs[4] = '{1'b0, 32'h1234_5678, 32'h0000_0003, 64'h0000_0000_369D_0368};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[6] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};
        vecs[8] = '{1'b0, 32'h0000_0000, 32'h0000_1234, 64'h0000_0000_0000_0000};
        vecs[9] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        is_signed = 1'b0;
        y         = '0;
        x         = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_product", product, 64'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd0);
            waitResult($sformatf("vec%0d", i), FIXED_LAT, 1'b1);
        end

        applyStimulus(1'b0, 32'h1234_5678, 32'h0000_0003, 64'h0000_0000_369D_0368);
        waitResult("early_term", ET_LAT, 1'b1);
        applyStimulus(1'b1, 32'h0000_0000, 32'h0000_0000, 64'h0);
        waitResult("zero_mult", ZERO_LAT, 1'b1);

        // Back-pressure with a competing operand pair offered while the result waits.
        applyStimulus(1'b0, 32'h0000_1234, 32'h0000_0010, 64'h0000_0000_0001_2340);
        waitResult("bp", FIXED_LAT, 1'b0);
        is_signed = 1'b1;
        y         = 32'hDEAD_BEEF;
        x         = 32'h0BAD_F00D;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_product_stable", product, 64'h0000_0000_0001_2340);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            checkOutput("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_retired_busy", 64'(busy), 64'd0);
        checkOutput("bp_retired_out_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_retired_in_ready", 64'(in_ready), 64'd1);

        // Reset during step 8 discards the in-flight result.
        applyStimulus(1'b1, 32'h1111_1111, 32'h2222_2222, 64'h0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_product", product, 64'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        checkOutput("midrst_no_valid_pulse", 64'(seen_valid), 64'd0);
        applyStimulus(1'b0, 32'd7, 32'd6, 64'd42);
        waitResult("post_rst_7x6", FIXED_LAT, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            applyStimulus(sgn, a, b, refModel(sgn, a, b));
`ifndef BOOTH_MULT_EARLY_TERM_EN
            if (i > 0) checkOutput("rand_throughput", 64'(last_accept - prev_accept), 64'd19);
`endif
            prev_accept = last_accept;
            waitResult("rand", FIXED_LAT, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
